// File: rtl/isle3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isle3_pkg
// Description : Shared definitions for the ISLE3 register file write-back
//               slice: default data/address widths, register count, the
//               register address/data typedefs and the zero-register index.
// Revision    : 1.0 - initial release
// ============================================================================
package isle3_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NREGS  = 2 ** DEF_ADDR_W;

    typedef logic [DEF_DATA_W-1:0] reg_data_t;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 3'b000;

endpackage : isle3_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Pending-write scoreboard. One busy bit per register, set on
//               issue and cleared on commit; a set and a clear to the same
//               register on the same edge leave the bit set, because the
//               set belongs to a newer, still outstanding write.
//               Also produces the read-after-write hazard flag, suppressed
//               when the read can be served from the staging register.
// Ports       : clk, rst_n            - clock, async active-low reset
//               set_en / set_idx      - issue of a write to set_idx
//               clr_en / clr_idx      - commit of a write to clr_idx
//               ra_en/ra_addr/fwd_a   - read port A use, address, forwardable
//               rb_en/rb_addr/fwd_b   - read port B use, address, forwardable
//               busy                  - pending-write vector
//               hazard                - enabled read hits an unresolved write
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_idx,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_idx,
    input  logic                   ra_en,
    input  logic [ADDR_W-1:0]      ra_addr,
    input  logic                   fwd_a,
    input  logic                   rb_en,
    input  logic [ADDR_W-1:0]      rb_addr,
    input  logic                   fwd_b,
    output logic [(2**ADDR_W)-1:0] busy,
    output logic                   hazard
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (set_en) w_set_mask[set_idx] = 1'b1;
        if (clr_en) w_clr_mask[clr_idx] = 1'b1;
    end

    // Clear first, then OR in the set, so a same-edge set survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign busy   = r_busy;
    assign hazard = (ra_en & r_busy[ra_addr] & ~fwd_a)
                  | (rb_en & r_busy[rb_addr] & ~fwd_b);

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_wb
// Description : 8-entry ISLE3 register file with a one-deep write-back
//               staging register, forwarding from that stage to two
//               combinational read ports, and a pending-write scoreboard.
//               A write captured at edge N is staged, then committed to the
//               array at edge N+1; while staged it is forwarded to reads.
//               Data presented on wr_data is not visible until staged.
// Ports       : clk, rst_n                - clock, async active-low reset
//               ra_en/ra_addr -> ra_data  - read port A
//               rb_en/rb_addr -> rb_data  - read port B
//               wr_en/wr_dst/wr_data      - write-back request
//               iss_en/iss_dst            - issue of a register-writing insn
//               hazard                    - RAW hazard to stall logic
//               busy                      - pending-write scoreboard vector
// Build macro : ISLE3_ZERO_REG_EN - register 0 hardwired to zero; writes,
//               commits and issues targeting it are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_wb
    import isle3_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ra_en,
    input  logic [ADDR_W-1:0]      ra_addr,
    output logic [DATA_W-1:0]      ra_data,
    input  logic                   rb_en,
    input  logic [ADDR_W-1:0]      rb_addr,
    output logic [DATA_W-1:0]      rb_data,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_dst,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   iss_en,
    input  logic [ADDR_W-1:0]      iss_dst,
    output logic                   hazard,
    output logic [(2**ADDR_W)-1:0] busy
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_wb_vld;
    logic [ADDR_W-1:0] r_wb_dst;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_wr_acc;
    logic              w_iss_set;
    logic              w_fwd_a;
    logic              w_fwd_b;

`ifdef ISLE3_ZERO_REG_EN
    // Dropping r0 writes at capture means nothing to r0 is ever staged,
    // forwarded or committed.
    assign w_wr_acc  = wr_en  & (wr_dst  != C_ZERO_ADDR);
    assign w_iss_set = iss_en & (iss_dst != C_ZERO_ADDR);
`else
    assign w_wr_acc  = wr_en;
    assign w_iss_set = iss_en;
`endif

    // Staging register and array commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_vld  <= 1'b0;
            r_wb_dst  <= '0;
            r_wb_data <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wb_vld <= w_wr_acc;
            if (w_wr_acc) begin
                r_wb_dst  <= wr_dst;
                r_wb_data <= wr_data;
            end
            if (r_wb_vld) begin
                r_regs[r_wb_dst] <= r_wb_data;
            end
        end
    end

    assign w_fwd_a = r_wb_vld & (r_wb_dst == ra_addr);
    assign w_fwd_b = r_wb_vld & (r_wb_dst == rb_addr);

    // Read ports: the staged write takes priority over the array contents.
    always_comb begin
        ra_data = w_fwd_a ? r_wb_data : r_regs[ra_addr];
        rb_data = w_fwd_b ? r_wb_data : r_regs[rb_addr];
`ifdef ISLE3_ZERO_REG_EN
        if (ra_addr == C_ZERO_ADDR) ra_data = '0;
        if (rb_addr == C_ZERO_ADDR) rb_data = '0;
`endif
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (w_iss_set),
        .set_idx (iss_dst),
        .clr_en  (r_wb_vld),
        .clr_idx (r_wb_dst),
        .ra_en   (ra_en),
        .ra_addr (ra_addr),
        .fwd_a   (w_fwd_a),
        .rb_en   (rb_en),
        .rb_addr (rb_addr),
        .fwd_b   (w_fwd_b),
        .busy    (busy),
        .hazard  (hazard)
    );

endmodule : reg_file_wb
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_wb
// Description : Self-checking bench for reg_file_wb. Inputs change on the
//               falling edge; outputs are compared shortly afterwards against
//               a behavioural model holding the register contents, the one
//               write waiting to land, and the set of registers with
//               outstanding writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_wb;
    import isle3_pkg::*;

    localparam int NR = DEF_NREGS;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ra_en, rb_en, wr_en, iss_en;
    reg_addr_t       ra_addr, rb_addr, wr_dst, iss_dst;
    reg_data_t       ra_data, rb_data, wr_data;
    logic            hazard;
    logic [NR-1:0]   busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_wb #(
        .DATA_W (DEF_DATA_W),
        .ADDR_W (DEF_ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_en   (ra_en),
        .ra_addr (ra_addr),
        .ra_data (ra_data),
        .rb_en   (rb_en),
        .rb_addr (rb_addr),
        .rb_data (rb_data),
        .wr_en   (wr_en),
        .wr_dst  (wr_dst),
        .wr_data (wr_data),
        .iss_en  (iss_en),
        .iss_dst (iss_dst),
        .hazard  (hazard),
        .busy    (busy)
    );

    // ---------------- reference model ----------------
    reg_data_t     m_regs [NR];
    logic          m_pend;       // a write is waiting to land
    reg_addr_t     m_pend_dst;
    reg_data_t     m_pend_data;
    logic [NR-1:0] m_busy;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_pend      = 1'b0;
        m_pend_dst  = '0;
        m_pend_data = '0;
        m_busy      = '0;
    endtask

    function automatic logic m_in_flight(reg_addr_t a);
        return m_pend && (m_pend_dst == a);
    endfunction

    function automatic reg_data_t m_read(reg_addr_t a);
`ifdef ISLE3_ZERO_REG_EN
        if (a == 0) return '0;
`endif
        if (m_in_flight(a)) return m_pend_data;
        return m_regs[a];
    endfunction

    function automatic logic m_hazard();
        logic ha, hb;
        ha = ra_en && m_busy[ra_addr] && !m_in_flight(ra_addr);
        hb = rb_en && m_busy[rb_addr] && !m_in_flight(rb_addr);
        return ha || hb;
    endfunction

    // Advance the model across one rising edge using the inputs that were
    // applied for this cycle.
    task automatic model_edge();
        logic [NR-1:0] nb;
        logic          keep_iss;
        nb = m_busy;
        if (m_pend) begin
            nb[m_pend_dst]       = 1'b0;
            m_regs[m_pend_dst]   = m_pend_data;
        end
        keep_iss = iss_en;
`ifdef ISLE3_ZERO_REG_EN
        if (iss_dst == 0) keep_iss = 1'b0;
`endif
        if (keep_iss) nb[iss_dst] = 1'b1;
        m_busy      = nb;
        m_pend      = wr_en;
`ifdef ISLE3_ZERO_REG_EN
        if (wr_dst == 0) m_pend = 1'b0;
`endif
        m_pend_dst  = wr_dst;
        m_pend_data = wr_data;
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        check_eq("ra_data", 32'(ra_data), 32'(m_read(ra_addr)));
        check_eq("rb_data", 32'(rb_data), 32'(m_read(rb_addr)));
        check_eq("hazard",  32'(hazard),  32'(m_hazard()));
        check_eq("busy",    32'(busy),    32'(m_busy));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        ra_en = 1'b0; rb_en = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
        ra_addr = '0; rb_addr = '0; wr_dst = '0; iss_dst = '0; wr_data = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset state on every address, both ports.
        for (int a = 0; a < NR; a++) begin
            ra_en = 1'b1; rb_en = 1'b1;
            ra_addr = reg_addr_t'(a);
            rb_addr = reg_addr_t'(NR - 1 - a);
            #1;
            check_eq("rst_ra", 32'(ra_data), 32'h0);
            check_eq("rst_rb", 32'(rb_data), 32'h0);
            check_eq("rst_hazard", 32'(hazard), 32'h0);
            check_eq("rst_busy", 32'(busy), 32'h0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        idle();

        // Write 0x1234 to r5: invisible, then forwarded, then from array.
        wr_en = 1'b1; wr_dst = 3'd5; wr_data = 16'h1234; ra_addr = 3'd5;
        #1; check_eq("r5_cycN", 32'(ra_data), 32'h0000); check_model();
        tick();
        wr_en = 1'b0;
        #1; check_eq("r5_fwd", 32'(ra_data), 32'h1234); check_model();
        tick();
        #1; check_eq("r5_array", 32'(ra_data), 32'h1234); check_model();
        tick();

        // Issue r3, read it: hazard until the write is staged.
        iss_en = 1'b1; iss_dst = 3'd3; ra_en = 1'b1; ra_addr = 3'd3;
        tick();
        iss_en = 1'b0;
        #1; check_eq("r3_haz", 32'(hazard), 32'h1); check_eq("r3_busy", 32'(busy), 32'h08);
        tick();
        wr_en = 1'b1; wr_dst = 3'd3; wr_data = 16'h3333;
        #1; check_eq("r3_haz_wr", 32'(hazard), 32'h1); check_model();
        tick();
        wr_en = 1'b0;
        #1; check_eq("r3_fwd_nohaz", 32'(hazard), 32'h0);
        check_eq("r3_fwd_busy", 32'(busy), 32'h08); check_model();
        tick();
        #1; check_eq("r3_commit_busy", 32'(busy), 32'h00);
        check_eq("r3_data", 32'(ra_data), 32'h3333); check_model();
        idle();

        // Set and clear of r2 on the same edge: set wins.
        iss_en = 1'b1; iss_dst = 3'd2;
        tick();
        iss_en = 1'b0; wr_en = 1'b1; wr_dst = 3'd2; wr_data = 16'h0002;
        tick();
        wr_en = 1'b0; iss_en = 1'b1; iss_dst = 3'd2;
        #1; check_model();
        tick();
        iss_en = 1'b0;
        #1; check_eq("same_edge_busy", 32'(busy), 32'h04); check_model();
        wr_en = 1'b1; wr_dst = 3'd2; wr_data = 16'h0022;
        tick();
        wr_en = 1'b0;
        tick();
        #1; check_eq("r2_cleared", 32'(busy), 32'h00); check_model();

        // Back-to-back writes to r1.
        wr_en = 1'b1; wr_dst = 3'd1; wr_data = 16'hAAAA;
        tick();
        wr_data = 16'hBBBB;
        #1; check_model();
        tick();
        wr_en = 1'b0; rb_addr = 3'd1; ra_addr = 3'd1;
        #1; check_eq("b2b_fwd", 32'(rb_data), 32'hBBBB); check_model();
        tick();
        #1; check_eq("b2b_array", 32'(ra_data), 32'hBBBB); check_model();
        idle();

        // Asynchronous reset while a write to r4 is staged.
        wr_en = 1'b1; wr_dst = 3'd4; wr_data = 16'h4444; iss_en = 1'b1; iss_dst = 3'd4;
        tick();
        wr_en = 1'b0; iss_en = 1'b0; ra_addr = 3'd4; ra_en = 1'b1;
        #1; check_eq("r4_staged", 32'(ra_data), 32'h4444);
        #1; rst_n = 1'b0;
        #1; model_reset();
        check_eq("async_ra", 32'(ra_data), 32'h0);
        check_eq("async_busy", 32'(busy), 32'h0);
        check_eq("async_haz", 32'(hazard), 32'h0);
        tick();
        rst_n = 1'b1;
        #1; check_eq("post_rst_r4", 32'(ra_data), 32'h0); check_model();
        tick();
        #1; check_eq("post_rst_r4b", 32'(ra_data), 32'h0);
        check_eq("post_rst_busy", 32'(busy), 32'h0);
        idle();

`ifdef ISLE3_ZERO_REG_EN
        // r0 hardwired to zero.
        wr_en = 1'b1; wr_dst = 3'd0; wr_data = 16'hFFFF; iss_en = 1'b1; iss_dst = 3'd0;
        tick();
        wr_en = 1'b0; iss_en = 1'b0; ra_en = 1'b1; ra_addr = 3'd0;
        #1; check_eq("r0_fwd", 32'(ra_data), 32'h0); check_eq("r0_haz", 32'(hazard), 32'h0);
        tick();
        #1; check_eq("r0_array", 32'(ra_data), 32'h0); check_eq("r0_busy", 32'(busy[0]), 32'h0);
        idle();
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            ra_en   = 1'($urandom_range(0, 1));
            rb_en   = 1'($urandom_range(0, 1));
            ra_addr = reg_addr_t'($urandom_range(0, NR - 1));
            rb_addr = ($urandom_range(0, 7) == 0) ? ra_addr
                                                  : reg_addr_t'($urandom_range(0, NR - 1));
            wr_en   = ($urandom_range(0, 99) < 45);
            wr_dst  = reg_addr_t'($urandom_range(0, NR - 1));
            wr_data = reg_data_t'($urandom);
            iss_en  = ($urandom_range(0, 99) < 35);
            iss_dst = reg_addr_t'($urandom_range(0, NR - 1));
            #1; check_model();
            tick();
        end

        idle();
        #1; check_model();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_reg_file_wb
`default_nettype wire
